// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU scheduler slice.
// Holds the data and opcode widths, the ALUOp codes and the scheduler FSM states.
package alu_pkg;

    localparam int OP_W   = 5;
    localparam int DATA_W = 32;

    localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
    localparam logic [OP_W-1:0] OP_AND  = 5'd2;
    localparam logic [OP_W-1:0] OP_OR   = 5'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 5'd4;
    localparam logic [OP_W-1:0] OP_SLL  = 5'd5;
    localparam logic [OP_W-1:0] OP_SRL  = 5'd6;
    localparam logic [OP_W-1:0] OP_SRA  = 5'd7;
    localparam logic [OP_W-1:0] OP_SLT  = 5'd8;
    localparam logic [OP_W-1:0] OP_SLTU = 5'd9;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_e;

endpackage

// File: rtl/alu_sched_if.sv
// Bundle of the two-requester request bus and the result channel.
// master = requesters/consumer side, slave = the scheduler.
interface alu_sched_if;
    import alu_pkg::*;

    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req_a0, req_b0, req_a1, req_b1;
    logic [OP_W-1:0]   req_op0, req_op1;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_y;
    logic              rsp_z, rsp_v, rsp_n;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1,
        output req_op0, req_op1, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y,
        input  rsp_z, rsp_v, rsp_n
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1,
        input  req_op0, req_op1, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y,
        output rsp_z, rsp_v, rsp_n
    );

endinterface

// File: rtl/alu.sv
// Combinational ALU: y = a op b with zero, signed-overflow and negative flags.
// Ports: a, b operands; op ALUOp; y result; z/v/n flags (v only for ADD/SUB).
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] y,
    output logic              z,
    output logic              v,
    output logic              n
);

    always_comb begin
        y = '0;
        v = 1'b0;
        case (op)
            OP_ADD: begin
                y = a + b;
                v = (a[DATA_W-1] == b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
                y = a - b;
                v = (a[DATA_W-1] != b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLL:  y = a << b[4:0];
            OP_SRL:  y = a >> b[4:0];
            OP_SRA:  y = $signed(a) >>> b[4:0];
            OP_SLT:  y = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: y = {{(DATA_W-1){1'b0}}, a < b};
            default: y = '0;
        endcase
        z = (y == '0);
        n = y[DATA_W-1];
    end

endmodule

// File: rtl/alu_sched_rr_arb2.sv
// Two-way round-robin arbiter with a one-bit priority pointer.
// Ports: req requests, advance = grant taken, init = pointer reset value, grant one-hot.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       init,
    output logic [1:0] grant
);

    logic prio_q, prio_d;

    always_comb begin
        grant  = (req == 2'b11) ? (prio_q ? 2'b10 : 2'b01) : req;
        prio_d = prio_q;
        // Priority passes to the requester that did not just win.
        if (advance) prio_d = grant[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prio_q <= init;
        else        prio_q <= prio_d;
    end

endmodule

// File: rtl/alu_sched.sv
// Schedules two requesters onto one shared ALU; result held in a 1-deep register.
// Ports: req_* request bus, rsp_* result channel; op_cnt when ALU_SCHED_CNT_EN is defined.
module alu_sched
    import alu_pkg::*;
#(
    parameter logic RR_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    input  logic [OP_W-1:0]   req_op0,
    input  logic [OP_W-1:0]   req_op1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_y,
    output logic              rsp_z,
    output logic              rsp_v,
    output logic              rsp_n
`ifdef ALU_SCHED_CNT_EN
    ,output logic [15:0]      op_cnt
`endif
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] y_q, y_d;
    logic              z_q, z_d, v_q, v_d, n_q, n_d, id_q, id_d;

    logic [1:0]        grant;
    logic              slot_free, accept, sel;
    logic [DATA_W-1:0] alu_a, alu_b, alu_y;
    logic [OP_W-1:0]   alu_op;
    logic              alu_z, alu_v, alu_n;

    // Slot frees up when empty or when the held result leaves this cycle.
    assign slot_free = (state_q == IDLE) || rsp_ready;
    assign req_ready = grant & {2{slot_free & rst_n}};
    assign accept    = |req_ready;
    assign sel       = req_ready[1];

    assign alu_a  = sel ? req_a1  : req_a0;
    assign alu_b  = sel ? req_b1  : req_b0;
    assign alu_op = sel ? req_op1 : req_op0;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (accept),
        .init    (RR_INIT),
        .grant   (grant)
    );

    alu u_alu (
        .a  (alu_a),
        .b  (alu_b),
        .op (alu_op),
        .y  (alu_y),
        .z  (alu_z),
        .v  (alu_v),
        .n  (alu_n)
    );

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        z_d     = z_q;
        v_d     = v_q;
        n_d     = n_q;
        id_d    = id_q;
        case (state_q)
            IDLE:    if (accept) state_d = FULL;
            FULL:    if (rsp_ready && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            y_d  = alu_y;
            z_d  = alu_z;
            v_d  = alu_v;
            n_d  = alu_n;
            id_d = sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= '0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
            n_q     <= 1'b0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            z_q     <= z_d;
            v_q     <= v_d;
            n_q     <= n_d;
            id_q    <= id_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_y     = y_q;
    assign rsp_z     = z_q;
    assign rsp_v     = v_q;
    assign rsp_n     = n_q;
    assign rsp_id    = id_q;

`ifdef ALU_SCHED_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (rsp_valid && rsp_ready) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign op_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: ALU vectors, round-robin, backpressure, reset.
// Expected values are hand-computed constants.
module tb_alu_sched;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    alu_sched_if u_if ();

`ifdef ALU_SCHED_CNT_EN
    logic [15:0] op_cnt;
`endif

    alu_sched #(.RR_INIT(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (u_if.req_valid),
        .req_ready (u_if.req_ready),
        .req_a0    (u_if.req_a0),
        .req_b0    (u_if.req_b0),
        .req_a1    (u_if.req_a1),
        .req_b1    (u_if.req_b1),
        .req_op0   (u_if.req_op0),
        .req_op1   (u_if.req_op1),
        .rsp_valid (u_if.rsp_valid),
        .rsp_ready (u_if.rsp_ready),
        .rsp_id    (u_if.rsp_id),
        .rsp_y     (u_if.rsp_y),
        .rsp_z     (u_if.rsp_z),
        .rsp_v     (u_if.rsp_v),
        .rsp_n     (u_if.rsp_n)
`ifdef ALU_SCHED_CNT_EN
        ,.op_cnt   (op_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        logic [31:0] y;
        logic        z;
        logic        v;
        logic        n;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pack();
        return {27'b0, u_if.rsp_valid, u_if.rsp_id, u_if.rsp_z,
                u_if.rsp_v, u_if.rsp_n, u_if.rsp_y};
    endfunction

    function automatic logic [63:0] ex(input logic id, input logic z,
                                       input logic v, input logic n,
                                       input logic [31:0] y);
        return {27'b0, 1'b1, id, z, v, n, y};
    endfunction

    // Drive one requester; the other gets junk operands it must not leak.
    task automatic set_req(input logic id, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] op);
        if (id) begin
            u_if.req_a1 = a; u_if.req_b1 = b; u_if.req_op1 = op;
            u_if.req_a0 = 32'hDEAD_BEEF; u_if.req_b0 = 32'h1; u_if.req_op0 = OP_SUB;
            u_if.req_valid = 2'b10;
        end else begin
            u_if.req_a0 = a; u_if.req_b0 = b; u_if.req_op0 = op;
            u_if.req_a1 = 32'hDEAD_BEEF; u_if.req_b1 = 32'h1; u_if.req_op1 = OP_SUB;
            u_if.req_valid = 2'b01;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, 32'h5,         32'h3,         OP_ADD,  32'h8,         1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'h7FFF_FFFF, 32'h1,         OP_ADD,  32'h8000_0000, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 32'h1234,      32'h1234,      OP_SUB,  32'h0,         1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 32'h0,         32'h1,         OP_SUB,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 32'h8000_0000, 32'h1,         OP_SUB,  32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 32'hF0F0,      32'h0FF0,      OP_AND,  32'h00F0,      1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 32'hF000,      32'h0F0F,      OP_OR,   32'hFF0F,      1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 32'hFFFF_0000, 32'h0FF0_0FF0, OP_XOR,  32'hF00F_0FF0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 32'h1,         32'd31,        OP_SLL,  32'h8000_0000, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 32'h8000_0000, 32'd4,         OP_SRA,  32'hF800_0000, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 32'h8000_0000, 32'd4,         OP_SRL,  32'h0800_0000, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 32'hFFFF_FFFF, 32'h1,         OP_SLT,  32'h1,         1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 32'hFFFF_FFFF, 32'h1,         OP_SLTU, 32'h0,         1'b1, 1'b0, 1'b0};

        u_if.req_valid = 2'b11;
        u_if.req_a0 = '0; u_if.req_b0 = '0; u_if.req_op0 = OP_ADD;
        u_if.req_a1 = '0; u_if.req_b1 = '0; u_if.req_op1 = OP_ADD;
        u_if.rsp_ready = 1'b1;

        // Reset state
        #3;
        chk("reset_ready", {62'b0, u_if.req_ready}, 64'h0);
        chk("reset_rsp", pack(), 64'h0);
        tick();
        tick();
        u_if.req_valid = 2'b00;
        rst_n = 1'b1;
        #1;
        chk("idle_rsp", pack(), 64'h0);

        // Contention: alternating grants, 1 op/cycle
        u_if.req_a0 = 32'd100; u_if.req_b0 = 32'd0; u_if.req_op0 = OP_ADD;
        u_if.req_a1 = 32'd200; u_if.req_b1 = 32'd0; u_if.req_op1 = OP_ADD;
        u_if.req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_grant", {62'b0, u_if.req_ready}, (k % 2) ? 64'h2 : 64'h1);
            tick();
            chk("rr_rsp", pack(),
                (k % 2) ? ex(1'b1, 1'b0, 1'b0, 1'b0, 32'd200)
                        : ex(1'b0, 1'b0, 1'b0, 1'b0, 32'd100));
        end
        u_if.req_valid = 2'b00;
        tick();

        // ALU vector table
        for (int i = 0; i < 13; i++) begin
            set_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op);
            #1;
            chk("vec_ready", {62'b0, u_if.req_ready},
                vecs[i].id ? 64'h2 : 64'h1);
            tick();
            u_if.req_valid = 2'b00;
            #1;
            chk("vec_rsp", pack(),
                ex(vecs[i].id, vecs[i].z, vecs[i].v, vecs[i].n, vecs[i].y));
            tick();
        end
        chk("vec_drain", {63'b0, u_if.rsp_valid}, 64'h0);

        // Backpressure: held result, req1 waits
        set_req(1'b0, 32'd10, 32'd20, OP_ADD);
        u_if.rsp_ready = 1'b0;
        #1;
        chk("bp_idle_ready", {62'b0, u_if.req_ready}, 64'h1);
        tick();
        set_req(1'b1, 32'd7, 32'd2, OP_SUB);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_ready", {62'b0, u_if.req_ready}, 64'h0);
            chk("bp_hold_rsp", pack(), ex(1'b0, 1'b0, 1'b0, 1'b0, 32'd30));
            tick();
        end
        u_if.rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", {62'b0, u_if.req_ready}, 64'h2);
        tick();
        u_if.req_valid = 2'b00;
        #1;
        chk("bp_next_rsp", pack(), ex(1'b1, 1'b0, 1'b0, 1'b0, 32'd5));
        tick();

        // Reset while FULL, pointer moved away from RR_INIT first
        set_req(1'b0, 32'd1, 32'd1, OP_ADD);
        u_if.rsp_ready = 1'b0;
        #1;
        tick();
        u_if.req_valid = 2'b00;
        #1;
        chk("rst_full_pre", pack(), ex(1'b0, 1'b0, 1'b0, 1'b0, 32'd2));
        u_if.req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        chk("rst_full_clear", pack(), 64'h0);
        chk("rst_full_ready", {62'b0, u_if.req_ready}, 64'h0);
        tick();
        u_if.req_valid = 2'b00;
        rst_n = 1'b1;
        u_if.rsp_ready = 1'b1;
        #1;
        tick();
        chk("rst_no_deliver", {63'b0, u_if.rsp_valid}, 64'h0);
        u_if.req_valid = 2'b11;
        #1;
        chk("rst_ptr", {62'b0, u_if.req_ready}, 64'h1);
        tick();
        u_if.req_valid = 2'b00;
        tick();

`ifdef ALU_SCHED_CNT_EN
        rst_n = 1'b0;
        #1;
        chk("cnt_reset", {48'b0, op_cnt}, 64'h0);
        rst_n = 1'b1;
        set_req(1'b0, 32'd1, 32'd2, OP_ADD);
        #1;
        tick();
        u_if.req_valid = 2'b00;
        tick();
        chk("cnt_one", {48'b0, op_cnt}, 64'h1);
        u_if.req_valid = 2'b01;
        for (int k = 0; k < 32'hFFFF; k++) tick();
        chk("cnt_ffff", {48'b0, op_cnt}, 64'hFFFF);
        u_if.req_valid = 2'b00;
        tick();
        chk("cnt_wrap", {48'b0, op_cnt}, 64'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
